bf_ifetch: RTL and testbench

//  Instruction fetch/loop-control stage between the program IROM (1-cycle sync read, q held while ce=0) and the

---
 rtl/bf_ifetch_pkg.sv | 28 ++
 rtl/bf_ifetch_if.sv | 27 ++
 rtl/bf_loop_stack.sv | 39 +++
 rtl/bf_ifetch.sv | 135 +++++++++++++
 tb/tb_bf_ifetch.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/bf_ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcode bytes, fetch
// state encodings and the op-byte classifier used by the comment filter.
package bf_ifetch_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_LOOP  = 8'h5B;
  localparam logic [7:0] OP_END   = 8'h5D;
  localparam logic [7:0] OP_HALT  = 8'h00;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_COND   = 3'd2;
  localparam logic [2:0] ST_SKIP   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  // True for the six ops that travel to the decoder (brackets/0x00 excluded).
  function automatic logic is_op(input logic [7:0] b);
    return (b == OP_INC) || (b == OP_DEC) || (b == OP_LEFT) ||
           (b == OP_RIGHT) || (b == OP_OUT) || (b == OP_IN);
  endfunction

endpackage

// File: rtl/bf_ifetch_if.sv
// IROM, decoder and datapath-condition signals of the fetch stage.
// master = fetch stage, slave = surrounding IROM/decoder/datapath.
interface bf_ifetch_if #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
);
  logic               irom_ce;
  logic [A_WIDTH-1:0] irom_a;
  logic [D_WIDTH-1:0] irom_q;
  logic               insn_valid;
  logic [D_WIDTH-1:0] insn;
  logic               insn_ready;
  logic               cond_valid;
  logic               cond_zero;
  logic               halted;
  logic               error;

  modport master (
    output irom_ce, irom_a, insn_valid, insn, halted, error,
    input  irom_q, insn_ready, cond_valid, cond_zero
  );

  modport slave (
    input  irom_ce, irom_a, insn_valid, insn, halted, error,
    output irom_q, insn_ready, cond_valid, cond_zero
  );
endinterface

// File: rtl/bf_loop_stack.sv
// Return-address LIFO for loop starts: 1<<STACK_AW entries of A_WIDTH bits.
// Sync reset clears only the pointer; entries above sp are don't-care.
module bf_loop_stack #(
  parameter int A_WIDTH  = 12,
  parameter int STACK_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [A_WIDTH-1:0] din,
  output logic [A_WIDTH-1:0] top,
  output logic               full,
  output logic               empty
);
  localparam int DEPTH = 1 << STACK_AW;

  logic [A_WIDTH-1:0]  mem [DEPTH];
  logic [STACK_AW:0]   sp;
  logic [STACK_AW-1:0] top_idx;
  logic [STACK_AW:0]   sp_dec;

  assign sp_dec  = sp - 1'b1;
  assign top_idx = sp_dec[STACK_AW-1:0];
  // sp never exceeds DEPTH, so the extra MSB alone marks a full stack
  assign full    = sp[STACK_AW];
  assign empty   = (sp == '0);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst)                 sp <= '0;
    else if (push && !full)  sp <= sp + 1'b1;
    else if (pop && !empty)  sp <= sp_dec;
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[sp[STACK_AW-1:0]] <= din;
  end
endmodule

// File: rtl/bf_ifetch.sv
// Instruction fetch / loop control: streams ops to the decoder and resolves
// brackets locally. Build option BF_IFETCH_COMMENT_FILTER_EN drops non-op bytes.
module bf_ifetch
  import bf_ifetch_pkg::*;
#(
  parameter int A_WIDTH  = 12,
  parameter int D_WIDTH  = 8,
  parameter int STACK_AW = 4
) (
  input logic          clk,
  input logic          rst,
  bf_ifetch_if.master  bus
);
  logic [2:0]         state, state_n;
  logic [A_WIDTH-1:0] pc, pc_n, pc_inc;
  logic [A_WIDTH-1:0] depth, depth_n;
  logic [A_WIDTH-1:0] a, stk_top;
  logic               ce, vld, push, pop, stk_full, stk_empty;
  logic [7:0]         op;

  assign op     = bus.irom_q[7:0];
  assign pc_inc = pc + 1'b1;

  bf_loop_stack #(.A_WIDTH(A_WIDTH), .STACK_AW(STACK_AW)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_n = state;
    pc_n    = pc;
    depth_n = depth;
    ce      = 1'b0;
    a       = pc;
    vld     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      ST_FETCH: begin
        ce      = 1'b1;
        state_n = ST_DECODE;
      end
      ST_DECODE: begin
        // address stays at pc+1 so it is stable across decoder back-pressure
        a = pc_inc;
        if (op == OP_HALT) state_n = ST_HALT;
        else if (op == OP_LOOP || op == OP_END) state_n = ST_COND;
`ifdef BF_IFETCH_COMMENT_FILTER_EN
        else if (!is_op(op)) begin
          ce   = 1'b1;
          pc_n = pc_inc;
        end
`endif
        else begin
          vld = 1'b1;
          if (bus.insn_ready) begin
            ce   = 1'b1;
            pc_n = pc_inc;
          end
        end
      end
      ST_COND: begin
        if (bus.cond_valid) begin
          if (op == OP_LOOP) begin
            if (!bus.cond_zero && stk_full) state_n = ST_ERR;
            else begin
              ce   = 1'b1;
              a    = pc_inc;
              pc_n = pc_inc;
              if (bus.cond_zero) begin
                depth_n = '0;
                state_n = ST_SKIP;
              end else begin
                push    = 1'b1;
                state_n = ST_DECODE;
              end
            end
          end else if (stk_empty) state_n = ST_ERR;
          else if (!bus.cond_zero) begin
            // loop again from the byte after the matching '[' (entry kept)
            ce      = 1'b1;
            a       = stk_top;
            pc_n    = stk_top;
            state_n = ST_DECODE;
          end else begin
            pop     = 1'b1;
            ce      = 1'b1;
            a       = pc_inc;
            pc_n    = pc_inc;
            state_n = ST_DECODE;
          end
        end
      end
      ST_SKIP: begin
        if (op == OP_HALT) state_n = ST_ERR;
        else begin
          ce   = 1'b1;
          a    = pc_inc;
          pc_n = pc_inc;
          if (op == OP_LOOP) depth_n = depth + 1'b1;
          else if (op == OP_END) begin
            if (depth == '0) state_n = ST_DECODE;
            else             depth_n = depth - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= '0;
      depth <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      depth <= depth_n;
    end
  end

  assign bus.irom_ce    = ce & ~rst;
  assign bus.irom_a     = rst ? '0 : a;
  assign bus.insn_valid = vld & ~rst;
  assign bus.insn       = rst ? '0 : bus.irom_q;
  assign bus.halted     = ((state == ST_HALT) || (state == ST_ERR)) & ~rst;
  assign bus.error      = (state == ST_ERR) & ~rst;
endmodule

// File: tb/tb_bf_ifetch.sv
// Directed bench for bf_ifetch: sync-read IROM model, per-bracket condition
// tables, and a negedge monitor logging emitted ops and IROM addresses.
module tb_bf_ifetch;
  import bf_ifetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bf_ifetch_if #(.A_WIDTH(12), .D_WIDTH(8)) bus ();
  bf_ifetch #(.A_WIDTH(12), .D_WIDTH(8), .STACK_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [4096];
  logic       lb_tab [64];
  logic       rb_tab [64];
  int         lb_idx = 0, rb_idx = 0;
  logic       lb_evt = 1'b0, rb_evt = 1'b0;
  int         cyc = 0;
  int         n_chk = 0, n_err = 0;
  logic [7:0] oplog [$];
  int         opcyc [$];
  int         alog  [$];
  int         exp_a [$];

  // IROM: one-cycle synchronous read, output held while ce is low
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) bus.irom_q <= '0;
    else if (bus.irom_ce) bus.irom_q <= rom[bus.irom_a];
    if (rst) begin
      lb_idx <= 0;
      rb_idx <= 0;
    end else begin
      if (lb_evt) lb_idx <= lb_idx + 1;
      if (rb_evt) rb_idx <= rb_idx + 1;
    end
  end

  always_comb begin
    bus.cond_zero = (bus.irom_q == OP_END) ? rb_tab[rb_idx] : lb_tab[lb_idx];
  end

  always @(negedge clk) begin
    if (bus.insn_valid && bus.insn_ready) begin
      oplog.push_back(bus.insn);
      opcyc.push_back(cyc);
    end
    if (bus.irom_ce) alog.push_back(int'(bus.irom_a));
    lb_evt <= bus.irom_ce && bus.cond_valid && (bus.irom_q == OP_LOOP);
    rb_evt <= bus.irom_ce && bus.cond_valid && (bus.irom_q == OP_END);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_tabs(input logic lbd, input logic rbd);
    for (int i = 0; i < 64; i++) begin
      lb_tab[i] = lbd;
      rb_tab[i] = rbd;
    end
  endtask

  // Assert reset, check forced-zero outputs, load program, clear logs, release.
  task automatic start(input string tag, input string s);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk({tag, "_rst_ce"}, bus.irom_ce, 0);
    chk({tag, "_rst_vld"}, bus.insn_valid, 0);
    chk({tag, "_rst_halt"}, bus.halted, 0);
    chk({tag, "_rst_err"}, bus.error, 0);
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
    @(posedge clk);
    @(posedge clk);
    #1;
    oplog.delete();
    opcyc.delete();
    alog.delete();
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (!bus.halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, bus.halted, 1);
  endtask

  task automatic chk_ops(input string tag, input string s);
    chk({tag, "_nops"}, oplog.size(), s.len());
    for (int i = 0; i < s.len() && i < oplog.size(); i++)
      chk({tag, "_op"}, oplog[i], s[i]);
  endtask

  task automatic chk_addrs(input string tag);
    chk({tag, "_naddr"}, alog.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < alog.size(); i++)
      chk({tag, "_addr"}, alog[i], exp_a[i]);
  endtask

  initial begin
    string s;
    int    n;
    bus.insn_ready = 1'b1;
    bus.cond_valid = 1'b1;
    set_tabs(1'b1, 1'b1);

    // 1: straight-line ops, one per cycle
    start("t1", "+-<>.,");
    wait_halt("t1", 100);
    chk_ops("t1", "+-<>.,");
    for (int i = 0; i < opcyc.size(); i++) chk("t1_cyc", opcyc[i] - opcyc[0], i);
    chk("t1_err", bus.error, 0);
    chk("t1_a", bus.irom_a, 6);
    chk("t1_vld", bus.insn_valid, 0);

    // 2: skipped loop, condition arrives late
    bus.cond_valid = 1'b0;
    start("t2", "[+]");
    repeat (4) @(negedge clk);
    chk("t2_wait_naddr", alog.size(), 1);
    chk("t2_wait_ce", bus.irom_ce, 0);
    chk("t2_wait_halt", bus.halted, 0);
    @(posedge clk);
    #1 bus.cond_valid = 1'b1;
    wait_halt("t2", 100);
    exp_a = '{0, 1, 2, 3};
    chk_addrs("t2");
    chk("t2_nops", oplog.size(), 0);
    chk("t2_a", bus.irom_a, 3);
    chk("t2_err", bus.error, 0);

    // 3: loop body runs three times
    set_tabs(1'b0, 1'b1);
    rb_tab[0] = 1'b0;
    rb_tab[1] = 1'b0;
    start("t3", "+[-]");
    wait_halt("t3", 100);
    chk_ops("t3", "+---");
    exp_a = '{0, 1, 2, 3, 2, 3, 2, 3, 4};
    chk_addrs("t3");
    chk("t3_err", bus.error, 0);
    chk("t3_a", bus.irom_a, 4);

    // 4: nested skip
    set_tabs(1'b1, 1'b1);
    start("t4", "[[+]]+");
    wait_halt("t4", 100);
    chk_ops("t4", "+");
    exp_a = '{0, 1, 2, 3, 4, 5, 6};
    chk_addrs("t4");
    chk("t4_err", bus.error, 0);

    // 5a: ']' on an empty stack
    start("t5a", "]");
    wait_halt("t5a", 100);
    chk("t5a_err", bus.error, 1);
    chk("t5a_nops", oplog.size(), 0);
    exp_a = '{0};
    chk_addrs("t5a");

    // 5b: 16 nested entries fit, the 17th overflows
    set_tabs(1'b0, 1'b0);
    s = "";
    for (int i = 0; i < 16; i++) s = {s, "["};
    start("t5b", s);
    wait_halt("t5b", 100);
    chk("t5b_err", bus.error, 0);
    chk("t5b_naddr", alog.size(), 17);
    s = {s, "["};
    start("t5c", s);
    wait_halt("t5c", 100);
    chk("t5c_err", bus.error, 1);
    chk("t5c_naddr", alog.size(), 17);
    chk("t5c_a", bus.irom_a, 16);

    // 6a: decoder back-pressure
    set_tabs(1'b1, 1'b1);
    bus.insn_ready = 1'b0;
    start("t6a", "+");
    n = 0;
    @(negedge clk);
    while (!bus.insn_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("t6a_vld", bus.insn_valid, 1);
      chk("t6a_insn", bus.insn, 8'h2B);
      chk("t6a_a", bus.irom_a, 1);
      chk("t6a_ce", bus.irom_ce, 0);
      @(negedge clk);
    end
    chk("t6a_nops_stall", oplog.size(), 0);
    @(posedge clk);
    #1 bus.insn_ready = 1'b1;
    wait_halt("t6a", 100);
    chk_ops("t6a", "+");

    // 6b: reset in the middle of a skip with one stack entry live
    lb_tab[0] = 1'b0;
    start("t6b", "[[+++++]");
    n = 0;
    @(negedge clk);
    while (alog.size() < 4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6b_reach_skip", alog.size(), 4);
    start("t6c", "]");
    wait_halt("t6c", 100);
    exp_a = '{0};
    chk_addrs("t6c");
    chk("t6c_err", bus.error, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
